// File: rtl/ram_rd_checker.sv
// Read-side checker for the test RAM: pairs each rden with the RAM q output and keeps error and burst-verdict statistics.
// Latency: compare RD_LAT cycles after a sampled read; pass_done RD_LAT+1 cycles after the last rden=1 cycle of a burst.
// Backpressure: none; pure observer that never stalls or drives the RAM.
module ram_rd_checker #(
  parameter int AW          = 5,
  parameter int DW          = 8,
  parameter int RD_LAT      = 1,
  parameter int DATA_OFFSET = 0,
  parameter int EXP_WORDS   = 32
) (
  input  logic          clk_50M,
  input  logic          RST,
  input  logic          rden,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] rddata,
  output logic [15:0]   err_cnt,
  output logic          first_err_valid,
  output logic [AW-1:0] first_err_addr,
  output logic [DW-1:0] first_err_data,
  output logic          pass_done,
  output logic          pass_ok,
  output logic [15:0]   pass_cnt
);

  typedef enum logic [1:0] {IDLE, CHECK, DRAIN, REPORT} state_t;

  localparam logic [AW:0]   WORDS_MAX  = '1;
  localparam logic [AW:0]   EXP_W      = (AW+1)'(EXP_WORDS);
  localparam logic [DW-1:0] OFFSET     = DW'(DATA_OFFSET);
  localparam logic [1:0]    DRAIN_INIT = 2'(RD_LAT-1);

  state_t        state, state_nxt;
  logic [1:0]    drain, drain_nxt;
  logic          burst_clr;

  logic [RD_LAT-1:0] stg_vld;
  logic [AW-1:0]     stg_addr [RD_LAT];

  logic          cmp_vld;
  logic [AW-1:0] cmp_addr;
  logic          cmp_bad;

  logic [AW:0]   words, words_base, words_nxt;
  logic          pass_err, err_base, pass_err_nxt;

  // Latency pipeline: carries each sampled read forward until its data arrives.
  always_ff @(posedge clk_50M or posedge RST) begin
    if (RST) begin
      stg_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) stg_addr[i] <= '0;
    end else begin
      stg_vld[0]  <= rden;
      stg_addr[0] <= address;
      for (int i = 1; i < RD_LAT; i++) begin
        stg_vld[i]  <= stg_vld[i-1];
        stg_addr[i] <= stg_addr[i-1];
      end
    end
  end

  assign cmp_vld  = stg_vld[RD_LAT-1];
  assign cmp_addr = stg_addr[RD_LAT-1];
  // Expected data follows the address of the read, so wrap within a burst is harmless.
  assign cmp_bad  = cmp_vld && (rddata != (DW'(cmp_addr) + OFFSET));

  // A new burst starts from zero; the compare landing this cycle (if any) is still counted.
  assign words_base   = burst_clr ? '0 : words;
  assign err_base     = burst_clr ? 1'b0 : pass_err;
  assign words_nxt    = (cmp_vld && (words_base != WORDS_MAX)) ? words_base + (AW+1)'(1) : words_base;
  assign pass_err_nxt = err_base | cmp_bad;

  // Burst framing: drain counts compares still outstanding after the current cycle,
  // so REPORT is entered on the same edge that retires the last compare.
  always_comb begin
    state_nxt = state;
    drain_nxt = drain;
    burst_clr = 1'b0;
    case (state)
      IDLE: begin
        if (rden) begin
          state_nxt = CHECK;
          burst_clr = 1'b1;
        end
      end
      CHECK: begin
        if (!rden) begin
          if (DRAIN_INIT == 2'd0) begin
            state_nxt = REPORT;
          end else begin
            state_nxt = DRAIN;
            drain_nxt = DRAIN_INIT;
          end
        end
      end
      DRAIN: begin
        if (rden) begin
          state_nxt = CHECK;
        end else begin
          drain_nxt = drain - 2'd1;
          if (drain == 2'd1) state_nxt = REPORT;
        end
      end
      REPORT: begin
        if (rden) begin
          state_nxt = CHECK;
          burst_clr = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, drain counter and per-burst statistics.
  always_ff @(posedge clk_50M or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      drain    <= '0;
      words    <= '0;
      pass_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      drain    <= drain_nxt;
      words    <= words_nxt;
      pass_err <= pass_err_nxt;
    end
  end

  // Cumulative error count and first-error capture; the capture is never overwritten.
  always_ff @(posedge clk_50M or posedge RST) begin
    if (RST) begin
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      first_err_data  <= '0;
    end else if (cmp_bad) begin
      if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      if (!first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_addr  <= cmp_addr;
        first_err_data  <= rddata;
      end
    end
  end

  // Verdict registers: loaded on the REPORT entry edge using the final burst statistics.
  always_ff @(posedge clk_50M or posedge RST) begin
    if (RST) begin
      pass_done <= 1'b0;
      pass_ok   <= 1'b0;
      pass_cnt  <= '0;
    end else begin
      pass_done <= (state_nxt == REPORT);
      if (state_nxt == REPORT) begin
        pass_ok  <= !pass_err_nxt && (words_nxt == EXP_W);
        pass_cnt <= pass_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/ram_rd_checker.md
Name: ram_rd_checker

Overview:
- Read-side checker for the single-port test RAM. The pattern generator fills the RAM, then drives rden with an incrementing address.
- This block watches rden, address and the RAM q output (rddata). It aligns each read with the RAM read latency and compares the returned data against the expected pattern.
- It keeps cumulative error statistics and reports a pass/fail verdict at the end of every read burst.
- Sits beside the RAM instance on clk_50M; purely an observer, it drives nothing into the RAM.

Parameters:
- AW, 5: address width.
- DW, 8: data width.
- RD_LAT, 1: clock cycles from a sampled rden=1 to valid rddata; legal range 1..4.
- DATA_OFFSET, 0: expected data = (address + DATA_OFFSET) mod 2^DW.
- EXP_WORDS, 32: reads required in one burst for that burst to pass.

Ports:
- clk_50M  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- rden  in  1  RAM read enable, as driven to the RAM.
- address  in  AW  RAM address, as driven to the RAM.
- rddata  in  DW  RAM q output.
- err_cnt  out  16  cumulative mismatch count since reset; saturates at 16'hFFFF.
- first_err_valid  out  1  sticky; set on the first mismatch since reset.
- first_err_addr  out  AW  address of the first mismatch; held until reset.
- first_err_data  out  DW  rddata returned by the first mismatch.
- pass_done  out  1  one-cycle pulse when a burst verdict is produced.
- pass_ok  out  1  verdict of the last burst; valid from pass_done onward, held until the next pass_done.
- pass_cnt  out  16  number of completed bursts; wraps modulo 2^16.

Behaviour:
- Reset: all outputs 0, pipeline valid bits 0, state IDLE, internal counters 0.
- Reset asserted mid-burst: the burst is abandoned, no pass_done is issued, all pipeline entries are discarded.
- Latency pipeline:
  - RD_LAT stages, each holding {vld, addr}.
  - Stage 0 loads {rden, address} every cycle.
  - At the last stage, when vld=1, compare rddata against (addr + DATA_OFFSET), truncated to DW.
- Mismatch:
  - err_cnt increments, saturating at 16'hFFFF.
  - pass_err sets.
  - If first_err_valid=0: capture addr and rddata, then set first_err_valid. Later mismatches do not overwrite the capture.
- Every compare (match or mismatch) increments words, saturating at 2^(AW+1)-1.
- FSM states: IDLE, CHECK, DRAIN, REPORT.
- IDLE:
  - rden=1 -> CHECK.
  - pass_err and words clear on this transition. The read sampled in this cycle belongs to the new burst.
- CHECK:
  - Stay while rden=1.
  - rden=0 -> DRAIN, with the drain counter loaded to RD_LAT-1.
- DRAIN:
  - Compares continue while the pipeline empties.
  - rden=1 during DRAIN -> back to CHECK; the burst is extended, not split.
  - Drain counter reaches 0 with rden=0 -> REPORT. The last compare of the burst lands in the same cycle as the REPORT transition and is included in the verdict.
- REPORT (exactly one cycle):
  - pass_done=1.
  - pass_ok = (pass_err==0) && (words==EXP_WORDS).
  - pass_cnt increments.
  - Next state is CHECK if rden=1 in this cycle (new burst; counters cleared, this cycle's read counted in the new burst), else IDLE.
- Verdict timing: pass_done is registered. It is asserted in the cycle after the REPORT transition edge, i.e. RD_LAT+1 cycles after the last rden=1 cycle for RD_LAT=1.
- Address wrap within a burst (31 -> 0) is legal; expected data follows the address, not a running counter.
- Compares with vld=0 are ignored; rddata is don't-care then.
- rden X or Z is not tolerated; the bench must drive rden to a known level at all times.

Test Plan:
1. Clean burst: RD_LAT=1, DATA_OFFSET=0. Reads of addresses 0..31 on consecutive cycles, RAM returning data=address -> one pass_done pulse, pass_ok=1, pass_cnt=1, err_cnt=0, first_err_valid=0.
2. Single corruption: same as test 1, but address 7 returns 8'hFF -> err_cnt=1, first_err_addr=7, first_err_data=8'hFF, pass_ok=0. A second clean burst then gives pass_ok=1, err_cnt still 1, first_err fields unchanged.
3. Short burst: only 20 reads, all correct -> pass_ok=0 (words=20≠32), err_cnt=0.
4. Latency and gaps: RD_LAT=3, DATA_OFFSET=8'h10.
   - 32 reads returning address+16, delayed 3 cycles -> pass_ok=1.
   - A 2-cycle rden gap inside the burst is shorter than the drain -> still one pass_done, pass_ok=1.
5. Back-to-back and reset: rden reasserts exactly in the REPORT cycle -> two pass_done pulses, pass_cnt=2, second burst counts 32 words. Then RST asserted at read 10 of a third burst -> all outputs 0 next cycle, no pass_done.
6. Saturation: force 70000 mismatching reads -> err_cnt holds at 16'hFFFF, first_err_addr is the first bad address.
